// File: rtl/conv_layer_ctrl.sv
// Layer sequencer for a convolution engine: streams weights/biases from DDR, then meters
// pixel handshakes per output-channel group. Optional cycle counter: CONV_LAYER_CTRL_PERF_CNT_EN.
module conv_layer_ctrl #(
  parameter int unsigned DDR_WIDTH = 256,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    cfg_w_beats,
  input  logic [3:0]           cfg_b_beats,
  input  logic [7:0]           cfg_groups,
  input  logic [CNT_W-1:0]     cfg_pix,
  input  logic [DDR_WIDTH-1:0] ddr_data_in,
  input  logic                 ddr_valid_in,
  output logic                 ddr_ready_out,
  output logic                 wmem_wr_en,
  output logic [ADDR_W-1:0]    wmem_wr_addr,
  output logic [DDR_WIDTH-1:0] wmem_wr_data,
  output logic                 bias_wr_en,
  output logic [3:0]           bias_wr_addr,
  input  logic                 mac_valid_in,
  output logic                 mac_ready_out,
  input  logic                 mac_valid_out,
  output logic [2:0]           current_state,
  output logic                 state_rst,
  output logic                 layer_done,
  output logic                 busy,
  output logic                 err_overrun
`ifdef CONV_LAYER_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoadW   = 3'd1,
    StLoadB   = 3'd2,
    StCompute = 3'd3,
    StDrain   = 3'd4,
    StDone    = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]    w_beats_q;
  logic [3:0]           b_beats_q;
  logic [7:0]           groups_q;
  logic [CNT_W-1:0]     pix_q;
  logic [ADDR_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [7:0]           grp_cnt_q, grp_cnt_d;
  logic                 err_q, err_d;
  logic                 wmem_wr_en_q, bias_wr_en_q, state_rst_q;
  logic [ADDR_W-1:0]    wmem_wr_addr_q;
  logic [3:0]           bias_wr_addr_q;
  logic [DDR_WIDTH-1:0] wr_data_q;

  logic                 accept_start;
  logic                 in_load;
  logic                 ddr_acc;
  logic [ADDR_W-1:0]    beat_target;
  logic [ADDR_W-1:0]    beat_nxt;
  logic                 load_done;
  logic                 mac_in_hs;
  logic [CNT_W-1:0]     in_nxt;
  logic                 in_done;
  logic                 out_ok;
  logic                 out_inc;
  logic [CNT_W-1:0]     out_nxt;
  logic                 out_done;
  logic [7:0]           grp_nxt;
  logic                 more_groups;
  logic                 drain_exit;

  assign accept_start = start && (state_q == StIdle);
  assign in_load      = (state_q == StLoadW) || (state_q == StLoadB);
  assign ddr_acc      = ddr_valid_in && ddr_ready_out;
  assign beat_target  = (state_q == StLoadW) ? w_beats_q : ADDR_W'(b_beats_q);
  assign beat_nxt     = beat_cnt_q + ADDR_W'(ddr_acc);
  // Look ahead by one beat so a phase ends in the cycle its last beat is taken.
  assign load_done    = (beat_nxt == beat_target);

  assign mac_in_hs    = mac_valid_in && mac_ready_out;
  assign in_nxt       = in_cnt_q + CNT_W'(mac_in_hs);
  assign in_done      = (in_nxt == pix_q);

  assign out_ok       = ((state_q == StCompute) || (state_q == StDrain)) && (out_cnt_q != pix_q);
  assign out_inc      = mac_valid_out && out_ok;
  assign out_nxt      = out_cnt_q + CNT_W'(out_inc);
  assign out_done     = (out_nxt == pix_q);

  assign grp_nxt      = grp_cnt_q + 8'd1;
  assign more_groups  = (grp_nxt < groups_q);
  assign drain_exit   = (state_q == StDrain) && out_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = StLoadW;
      StLoadW:   if (load_done) state_d = StLoadB;
      StLoadB:   if (load_done) state_d = StCompute;
      StCompute: if (in_done) state_d = StDrain;
      StDrain:   if (out_done) state_d = more_groups ? StLoadW : StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    current_state = state_q;
    busy          = (state_q != StIdle);
    layer_done    = (state_q == StDone);
    ddr_ready_out = in_load && (beat_cnt_q != beat_target);
    mac_ready_out = (state_q == StCompute) && (in_cnt_q != pix_q);
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    err_d      = err_q;
    if (in_load) beat_cnt_d = load_done ? '0 : beat_nxt;
    if (state_q == StCompute) in_cnt_d = in_nxt;
    if (out_inc) out_cnt_d = out_nxt;
    if (mac_valid_out && !out_ok) err_d = 1'b1;
    if (drain_exit) begin
      grp_cnt_d = grp_nxt;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
    // A fresh layer wins over any stray result strobe in the same cycle.
    if (accept_start) begin
      beat_cnt_d = '0;
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      grp_cnt_d  = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_beats_q      <= '0;
      b_beats_q      <= '0;
      groups_q       <= '0;
      pix_q          <= '0;
      beat_cnt_q     <= '0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      grp_cnt_q      <= '0;
      err_q          <= 1'b0;
      wmem_wr_en_q   <= 1'b0;
      bias_wr_en_q   <= 1'b0;
      state_rst_q    <= 1'b0;
      wmem_wr_addr_q <= '0;
      bias_wr_addr_q <= '0;
      wr_data_q      <= '0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      err_q        <= err_d;
      wmem_wr_en_q <= ddr_acc && (state_q == StLoadW);
      bias_wr_en_q <= ddr_acc && (state_q == StLoadB);
      state_rst_q  <= drain_exit && more_groups;
      if (ddr_acc) begin
        wr_data_q <= ddr_data_in;
        if (state_q == StLoadW) wmem_wr_addr_q <= beat_cnt_q;
        else bias_wr_addr_q <= beat_cnt_q[3:0];
      end
      if (accept_start) begin
        w_beats_q <= cfg_w_beats;
        b_beats_q <= cfg_b_beats;
        groups_q  <= (cfg_groups == 8'd0) ? 8'd1 : cfg_groups;
        pix_q     <= cfg_pix;
      end
    end
  end

  assign wmem_wr_en   = wmem_wr_en_q;
  assign wmem_wr_addr = wmem_wr_addr_q;
  assign wmem_wr_data = wr_data_q;
  assign bias_wr_en   = bias_wr_en_q;
  assign bias_wr_addr = bias_wr_addr_q;
  assign state_rst    = state_rst_q;
  assign err_overrun  = err_q;

`ifdef CONV_LAYER_CTRL_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (accept_start) begin
      perf_q <= '0;
    end else if (busy && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Randomized bench for conv_layer_ctrl: a transaction-level model of the layer sequence is
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_conv_layer_ctrl;
  localparam int DW = 256;
  localparam int AW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_w_beats;
  logic [3:0]    cfg_b_beats;
  logic [7:0]    cfg_groups;
  logic [CW-1:0] cfg_pix;
  logic [DW-1:0] ddr_data_in;
  logic          ddr_valid_in, ddr_ready_out;
  logic          wmem_wr_en;
  logic [AW-1:0] wmem_wr_addr;
  logic [DW-1:0] wmem_wr_data;
  logic          bias_wr_en;
  logic [3:0]    bias_wr_addr;
  logic          mac_valid_in, mac_ready_out, mac_valid_out;
  logic [2:0]    current_state;
  logic          state_rst, layer_done, busy, err_overrun;
`ifdef CONV_LAYER_CTRL_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  conv_layer_ctrl #(.DDR_WIDTH(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_w_beats(cfg_w_beats), .cfg_b_beats(cfg_b_beats), .cfg_groups(cfg_groups),
    .cfg_pix(cfg_pix),
    .ddr_data_in(ddr_data_in), .ddr_valid_in(ddr_valid_in), .ddr_ready_out(ddr_ready_out),
    .wmem_wr_en(wmem_wr_en), .wmem_wr_addr(wmem_wr_addr), .wmem_wr_data(wmem_wr_data),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
    .mac_valid_in(mac_valid_in), .mac_ready_out(mac_ready_out), .mac_valid_out(mac_valid_out),
    .current_state(current_state), .state_rst(state_rst), .layer_done(layer_done),
    .busy(busy), .err_overrun(err_overrun)
`ifdef CONV_LAYER_CTRL_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number (spec encoding) plus progress counts within the layer.
  int          m_st = 0, m_beat = 0, m_in = 0, m_out = 0, m_grp = 0;
  int          m_w = 0, m_b = 0, m_g = 0, m_pix = 0;
  bit          m_wen = 0, m_ben = 0, m_srst = 0, m_err = 0;
  int          m_waddr = 0, m_baddr = 0;
  logic [DW-1:0] m_data = '0;
  logic [31:0] m_perf = '0;

  // Events observed on DUT outputs, for the directed literal checks.
  int ev_w, ev_b, ev_mi, ev_mo, ev_done, ev_srst, ev_ddr, ev_busy, last_waddr, last_baddr;

  task automatic clr_ev();
    ev_w = 0; ev_b = 0; ev_mi = 0; ev_mo = 0; ev_done = 0; ev_srst = 0; ev_ddr = 0;
    ev_busy = 0; last_waddr = -1; last_baddr = -1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_st = 0; m_beat = 0; m_in = 0; m_out = 0; m_grp = 0; m_err = 0;
      m_wen = 0; m_ben = 0; m_srst = 0; m_perf = '0;
      chk("rst_state", current_state, 0);
      chk("rst_outputs", {ddr_ready_out, wmem_wr_en, bias_wr_en, mac_ready_out, state_rst,
                          layer_done, busy, err_overrun}, 0);
      chk("rst_wr_fields", {wmem_wr_addr, bias_wr_addr}, 0);
      chk("rst_wr_data", wmem_wr_data, 0);
    end else begin
      bit dacc, mhs;
      chk("state", current_state, m_st);
      chk("busy", busy, m_st != 0);
      chk("layer_done", layer_done, m_st == 5);
      chk("ddr_ready", ddr_ready_out, (m_st == 1 && m_beat < m_w) || (m_st == 2 && m_beat < m_b));
      chk("mac_ready", mac_ready_out, m_st == 3 && m_in < m_pix);
      chk("state_rst", state_rst, m_srst);
      chk("err_overrun", err_overrun, m_err);
      chk("wmem_wr_en", wmem_wr_en, m_wen);
      chk("bias_wr_en", bias_wr_en, m_ben);
      if (m_wen) begin
        chk("wmem_wr_addr", wmem_wr_addr, m_waddr);
        chk("wmem_wr_data", wmem_wr_data, m_data);
      end
      if (m_ben) begin
        chk("bias_wr_addr", bias_wr_addr, m_baddr);
        chk("bias_wr_data", wmem_wr_data, m_data);
      end
`ifdef CONV_LAYER_CTRL_PERF_CNT_EN
      chk("perf_cycles", perf_cycles, m_perf);
`endif
      if (wmem_wr_en) begin ev_w++; last_waddr = int'(wmem_wr_addr); end
      if (bias_wr_en) begin ev_b++; last_baddr = int'(bias_wr_addr); end
      if (mac_valid_in && mac_ready_out) ev_mi++;
      if (mac_valid_out) ev_mo++;
      if (layer_done) ev_done++;
      if (state_rst) ev_srst++;
      if (ddr_valid_in && ddr_ready_out) ev_ddr++;
      if (busy) ev_busy++;

      // Advance the model by one clock using the inputs currently applied.
      dacc = ddr_valid_in && ((m_st == 1 && m_beat < m_w) || (m_st == 2 && m_beat < m_b));
      mhs  = mac_valid_in && m_st == 3 && m_in < m_pix;
      if (m_st != 0 && m_perf != 32'hffff_ffff) m_perf++;
      m_wen = 0; m_ben = 0; m_srst = 0;
      if (mac_valid_out) begin
        if ((m_st == 3 || m_st == 4) && m_out < m_pix) m_out++;
        else m_err = 1;
      end
      case (m_st)
        0: if (start) begin
          m_w = int'(cfg_w_beats); m_b = int'(cfg_b_beats); m_pix = int'(cfg_pix);
          m_g = (cfg_groups == 0) ? 1 : int'(cfg_groups);
          m_beat = 0; m_in = 0; m_out = 0; m_grp = 0; m_err = 0; m_perf = '0; m_st = 1;
        end
        1: begin
          if (dacc) begin m_wen = 1; m_waddr = m_beat; m_data = ddr_data_in; m_beat++; end
          if (m_beat == m_w) begin m_beat = 0; m_st = 2; end
        end
        2: begin
          if (dacc) begin m_ben = 1; m_baddr = m_beat; m_data = ddr_data_in; m_beat++; end
          if (m_beat == m_b) begin m_beat = 0; m_st = 3; end
        end
        3: begin
          if (mhs) m_in++;
          if (m_in == m_pix) m_st = 4;
        end
        4: if (m_out == m_pix) begin
          m_grp++; m_in = 0; m_out = 0;
          if (m_grp < m_g) begin m_st = 1; m_srst = 1; end
          else m_st = 5;
        end
        5: m_st = 0;
        default: m_st = 0;
      endcase
    end
  end

  int  ddr_rate = 100, mi_rate = 100, mo_rate = 100;
  bit  force_out = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
    start         = 1'b0;
    ddr_valid_in  = ($urandom_range(99) < ddr_rate);
    ddr_data_in   = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
    mac_valid_in  = ($urandom_range(99) < mi_rate);
    mac_valid_out = force_out ||
                    ((m_st == 3 || m_st == 4) && m_out < m_in && $urandom_range(99) < mo_rate);
  endtask

  task automatic do_start(input int w, input int b, input int g, input int p);
    cycle();
    cfg_w_beats = AW'(w);
    cfg_b_beats = 4'(b);
    cfg_groups  = 8'(g);
    cfg_pix     = CW'(p);
    start       = 1'b1;
  endtask

  task automatic wait_state(input int s);
    for (int i = 0; i < 3000; i++) begin
      if (int'(current_state) == s) return;
      cycle();
    end
    chk("wait_state_timeout", current_state, s);
  endtask

  task automatic run_layer(input int w, input int b, input int g, input int p);
    do_start(w, b, g, p);
    cycle();
    wait_state(5);
    cycle();
    cycle();
  endtask

  initial begin
    rst = 1'b1; start = 0; cfg_w_beats = 0; cfg_b_beats = 0; cfg_groups = 0; cfg_pix = 0;
    ddr_data_in = '0; ddr_valid_in = 0; mac_valid_in = 0; mac_valid_out = 0;
    clr_ev();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycle();

    // Single group, DDR always valid, results one cycle behind inputs.
    clr_ev();
    run_layer(4, 2, 1, 8);
    chk("t1_wmem_writes", ev_w, 4);
    chk("t1_last_waddr", last_waddr, 3);
    chk("t1_bias_writes", ev_b, 2);
    chk("t1_last_baddr", last_baddr, 1);
    chk("t1_mac_in", ev_mi, 8);
    chk("t1_mac_out", ev_mo, 8);
    chk("t1_done", ev_done, 1);
    chk("t1_state_rst", ev_srst, 0);
    chk("t1_busy_cycles", ev_busy, 16);
`ifdef CONV_LAYER_CTRL_PERF_CNT_EN
    chk("t1_perf", perf_cycles, 16);
`endif

    // Three groups.
    clr_ev();
    run_layer(2, 1, 3, 3);
    chk("t2_state_rst", ev_srst, 2);
    chk("t2_wmem_writes", ev_w, 6);
    chk("t2_bias_writes", ev_b, 3);
    chk("t2_done", ev_done, 1);

    // Nine results against eight pixels.
    clr_ev();
    mi_rate = 0;
    do_start(1, 0, 1, 8);
    cycle();
    wait_state(3);
    force_out = 1;
    repeat (9) cycle();
    force_out = 0;
    cycle();
    chk("t3_err_set", err_overrun, 1);
    mi_rate = 100;
    wait_state(5);
    cycle();
    chk("t3_mac_out", ev_mo, 9);
    chk("t3_err_sticky", err_overrun, 1);
    do_start(0, 0, 1, 0);
    cycle();
    chk("t3_err_cleared", err_overrun, 0);
    wait_state(5);
    cycle();

    // Empty layer: no DDR or MAC traffic at all.
    clr_ev();
    run_layer(0, 0, 0, 0);
    chk("t4_ddr_beats", ev_ddr, 0);
    chk("t4_mac_in", ev_mi, 0);
    chk("t4_done", ev_done, 1);
    chk("t4_busy_cycles", ev_busy, 5);

    // Reset in the middle of the weight load.
    clr_ev();
    do_start(6, 1, 1, 4);
    for (int i = 0; i < 100 && ev_w < 2; i++) cycle();
    chk("t5_reached_beat2", ev_w, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_state", current_state, 0);
    chk("t5_rst_flags", {ddr_ready_out, wmem_wr_en, bias_wr_en, mac_ready_out, busy}, 0);
    chk("t5_rst_addr", wmem_wr_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle();
    chk("t5_stays_idle", busy, 0);

    // Start while in DONE is ignored.
    do_start(0, 0, 1, 0);
    cycle();
    wait_state(5);
    cfg_w_beats = 4; cfg_b_beats = 2; cfg_groups = 1; cfg_pix = 8;
    start = 1'b1;
    repeat (3) cycle();
    chk("t5_done_start_ignored", busy, 0);

    // Randomized layers.
    for (int k = 0; k < 12; k++) begin
      ddr_rate = $urandom_range(100, 30);
      mi_rate  = $urandom_range(100, 30);
      mo_rate  = $urandom_range(100, 30);
      clr_ev();
      run_layer($urandom_range(5), $urandom_range(3), $urandom_range(3), $urandom_range(6));
      chk("rand_done", ev_done, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
